// File: rtl/trigger_srl_loader_pkg.sv
// Shared types and constants for the SRLC32E trigger table loader.
// State encoding and table geometry live here.
package trigger_srl_loader_pkg;

  localparam int SRL_DEPTH = 32;
  localparam int TBL_W     = 32;
  localparam int CNT_W     = $clog2(SRL_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/trigger_srl_loader_if.sv
// Host config handshake: one truth-table write per transfer.
// The loader is the slave; the host is the master.
interface trigger_srl_loader_if
  import trigger_srl_loader_pkg::*;
#(
  parameter int CH_BITS = 2
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_BITS-1:0] cfg_chan;
  logic [TBL_W-1:0]   cfg_table;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_table,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_table,
    output cfg_ready
  );

endinterface

// File: rtl/trigger_srl_loader.sv
// Serially reloads SRLC32E trigger truth tables, MSB first,
// and masks each trigger while its table is not fully loaded.
module trigger_srl_loader
  import trigger_srl_loader_pkg::*;
#(
  parameter int NUM_SRL = 4,
  parameter int CH_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  trigger_srl_loader_if.slave cfg,
  output logic [NUM_SRL-1:0] srl_ce,
  output logic               srl_din,
  input  logic [NUM_SRL-1:0] srl_q,
  output logic [NUM_SRL-1:0] trig_out,
  output logic [NUM_SRL-1:0] table_valid,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CH_BITS-1:0] chan_q, chan_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [NUM_SRL-1:0] ce_q, ce_d;
  logic [NUM_SRL-1:0] valid_q, valid_d;
  logic               din_q, din_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               in_range;
  logic [NUM_SRL-1:0] req_mask;
  logic [NUM_SRL-1:0] chan_mask;

  assign cfg.cfg_ready = (state_q == ST_IDLE) & ~reset;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign in_range      = 32'(cfg.cfg_chan) < 32'(NUM_SRL);
  assign req_mask      = NUM_SRL'(1) << cfg.cfg_chan;
  assign chan_mask     = NUM_SRL'(1) << chan_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    chan_d   = chan_q;
    table_d  = table_q;
    ce_d     = ce_q;
    valid_d  = valid_q;
    din_d    = din_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && in_range) begin
          state_d  = ST_SHIFT;
          chan_d   = cfg.cfg_chan;
          table_d  = cfg.cfg_table;
          bitcnt_d = CNT_W'(SRL_DEPTH - 1);
          ce_d     = req_mask;
          din_d    = cfg.cfg_table[TBL_W-1];
          valid_d  = valid_q & ~req_mask;
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      // bitcnt names the bit currently on srl_din
      ST_SHIFT: begin
        if (bitcnt_q == '0) begin
          state_d = ST_DONE;
          ce_d    = '0;
          din_d   = 1'b0;
          done_d  = 1'b1;
          valid_d = valid_q | chan_mask;
        end else begin
          bitcnt_d = bitcnt_q - CNT_W'(1);
          din_d    = table_q[bitcnt_q - CNT_W'(1)];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      chan_q   <= '0;
      table_q  <= '0;
      ce_q     <= '0;
      valid_q  <= '0;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      chan_q   <= chan_d;
      table_q  <= table_d;
      ce_q     <= ce_d;
      valid_q  <= valid_d;
      din_q    <= din_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign srl_ce      = ce_q;
  assign srl_din     = din_q;
  assign table_valid = valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign trig_out    = srl_q & valid_q;

endmodule

// File: tb/tb_trigger_srl_loader.sv
// Randomised bench for trigger_srl_loader with an SRL shift model
// and a per-channel validity model.
module tb_trigger_srl_loader;
  localparam int N  = 4;
  localparam int CB = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] srl_ce, srl_q, trig_out, table_valid;
  logic         srl_din, done, err;

  always #5 clk = ~clk;

  trigger_srl_loader_if #(.CH_BITS(CB)) cfg ();

  trigger_srl_loader #(.NUM_SRL(N), .CH_BITS(CB)) dut (
    .clk(clk), .reset(reset), .cfg(cfg),
    .srl_ce(srl_ce), .srl_din(srl_din), .srl_q(srl_q),
    .trig_out(trig_out), .table_valid(table_valid),
    .done(done), .err(err)
  );

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  sr [N];
  logic [N-1:0] exp_valid = '0;
  logic [N-1:0] q_drv = '0;
  bit           q_ones = 0;
  int           ce_cycles = 0, starts = 0, bad_hot = 0;
  logic [N-1:0] ce_prev = '0;

  assign srl_q = q_drv;

  // behavioural SRLC32E: bit0 -> bit31 on each CE
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (srl_ce[i]) sr[i] <= {sr[i][30:0], srl_din};

  always @(negedge clk) begin
    if (srl_ce != '0) ce_cycles++;
    if (srl_ce != '0 && ce_prev == '0) starts++;
    if ($countones(srl_ce) > 1) bad_hot++;
    ce_prev = srl_ce;
  end

  task automatic load(input int ch, input logic [31:0] tbl,
                      input bit hold, output int t_acc);
    int guard, b_ce, b_din, b_trig, b_val;
    logic [N-1:0] m;
    m = N'(1) << ch;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan  = CB'(ch);
    cfg.cfg_table = tbl;
    guard = 0;
    while (!cfg.cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ch=%0d ready=%b want 1", ch, cfg.cfg_ready);
      cfg.cfg_valid = 1'b0;
      t_acc = 0;
      return;
    end
    @(posedge clk);
    t_acc = int'($time / 10);
    exp_valid[ch] = 1'b0;
    @(negedge clk);
    if (!hold) cfg.cfg_valid = 1'b0;
    b_ce = 0; b_din = 0; b_trig = 0; b_val = 0;
    for (int n = 1; n <= 32; n++) begin
      if (n > 1) @(negedge clk);
      q_drv = q_ones ? '1 : N'($urandom);
      #1;
      if (srl_ce !== m) b_ce++;
      if (srl_din !== tbl[32-n]) b_din++;
      if (trig_out !== (q_drv & exp_valid)) b_trig++;
      if (table_valid !== exp_valid || done !== 1'b0) b_val++;
    end
    checks++;
    if (b_ce != 0) begin errors++;
      $display("FAIL shift_ce ch=%0d bad_cycles=%0d want 0", ch, b_ce); end
    checks++;
    if (b_din != 0) begin errors++;
      $display("FAIL shift_din ch=%0d tbl=%h bad_bits=%0d want 0", ch, tbl, b_din); end
    checks++;
    if (b_trig != 0) begin errors++;
      $display("FAIL trig_mask ch=%0d bad_cycles=%0d want 0", ch, b_trig); end
    checks++;
    if (b_val != 0) begin errors++;
      $display("FAIL valid_during_shift ch=%0d bad_cycles=%0d want 0", ch, b_val); end
    @(negedge clk);
    exp_valid[ch] = 1'b1;
    checks++;
    if (done !== 1'b1 || srl_ce !== '0 || table_valid !== exp_valid
        || cfg.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle ch=%0d done=%b ce=%b valid=%b rdy=%b want 1 0 %b 0",
               ch, done, srl_ce, table_valid, cfg.cfg_ready, exp_valid);
    end
    checks++;
    if (sr[ch] !== tbl) begin errors++;
      $display("FAIL srl_contents ch=%0d got=%h want=%h", ch, sr[ch], tbl); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_again ch=%0d done=%b rdy=%b want 0 1",
               ch, done, cfg.cfg_ready);
    end
  endtask

  task automatic load_bad(input int ch);
    int guard;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan  = CB'(ch);
    cfg.cfg_table = $urandom;
    guard = 0;
    while (!cfg.cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || srl_ce !== '0 || table_valid !== exp_valid
        || cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse ch=%0d err=%b ce=%b valid=%b rdy=%b want 1 0 %b 1",
               ch, err, srl_ce, table_valid, cfg.cfg_ready, exp_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || srl_ce !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_after ch=%0d err=%b ce=%b done=%b want 0 0 0",
               ch, err, srl_ce, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_chan  = '0;
    cfg.cfg_table = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cfg.cfg_ready !== 1'b0 || srl_ce !== '0 || srl_din !== 1'b0
        || table_valid !== '0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL in_reset rdy=%b ce=%b din=%b valid=%b done=%b err=%b want all 0",
               cfg.cfg_ready, srl_ce, srl_din, table_valid, done, err);
    end
    reset = 1'b0;
    exp_valid = '0;
    @(negedge clk);
    checks++;
    if (cfg.cfg_ready !== 1'b1 || srl_ce !== '0 || table_valid !== '0) begin
      errors++;
      $display("FAIL after_reset rdy=%b ce=%b valid=%b want 1 0 0",
               cfg.cfg_ready, srl_ce, table_valid);
    end
  endtask

  task automatic test_basic();
    int t;
    q_ones = 0;
    load(0, 32'hAAAA_AAAA, 0, t);
    for (int i = 0; i < 4; i++) load($urandom_range(0, N-1), $urandom, 0, t);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    load(2, 32'h8000_0001, 1, t1);
    load(2, 32'h0000_FFFF, 0, t2);
    checks++;
    if (t2 - t1 != 34) begin errors++;
      $display("FAIL b2b_spacing got=%0d want 34", t2 - t1); end
  endtask

  task automatic test_trig_mask();
    int t;
    for (int c = 0; c < N; c++) load(c, $urandom, 0, t);
    checks++;
    if (table_valid !== 4'b1111) begin errors++;
      $display("FAIL all_valid got=%b want 1111", table_valid); end
    q_ones = 1;
    load(1, $urandom, 0, t);
    q_ones = 0;
    q_drv = '1;
    #1;
    checks++;
    if (trig_out !== 4'b1111) begin errors++;
      $display("FAIL trig_after_done got=%b want 1111", trig_out); end
  endtask

  task automatic test_err();
    load_bad(5);
    load_bad($urandom_range(N, 7));
  endtask

  task automatic test_reset_mid();
    int guard, bad;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan  = CB'(3);
    cfg.cfg_table = $urandom;
    guard = 0;
    while (!cfg.cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (srl_ce !== '0 || table_valid !== '0 || done !== 1'b0
        || cfg.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ce=%b valid=%b done=%b rdy=%b want 0 0 0 0",
               srl_ce, table_valid, done, cfg.cfg_ready);
    end
    reset = 1'b0;
    exp_valid = '0;
    @(negedge clk);
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL reset_mid_ready got=%b want 1", cfg.cfg_ready); end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || srl_ce !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL reset_mid_quiet bad_cycles=%0d want 0", bad); end
  endtask

  task automatic test_continuous();
    int t;
    int k = 6;
    starts = 0;
    ce_cycles = 0;
    for (int i = 0; i < k; i++)
      load($urandom_range(0, N-1), $urandom, (i != k-1), t);
    repeat (3) @(negedge clk);
    checks++;
    if (starts != k) begin errors++;
      $display("FAIL cont_loads got=%0d want %0d", starts, k); end
    checks++;
    if (ce_cycles != 32 * k) begin errors++;
      $display("FAIL cont_ce_cycles got=%0d want %0d", ce_cycles, 32 * k); end
    checks++;
    if (bad_hot != 0) begin errors++;
      $display("FAIL ce_onehot bad=%0d want 0", bad_hot); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_trig_mask();
    test_err();
    test_reset_mid();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
